// File: rtl/fetch_stage.sv
// Instruction-fetch stage: holds the architectural PC, fetches over a req/ack
// memory handshake and hands instructions to decode over valid/ready.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] next_pc,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        if_ready,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_REQ   = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic        req_q, req_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic [31:0] count_q, count_d;
  logic        squash_q, squash_d;

  function automatic logic [31:0] align_word(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_START;
      pc_q     <= RESET_PC;
      addr_q   <= align_word(RESET_PC);
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
      instr_q  <= 32'h0000_0000;
      ipc_q    <= 32'h0000_0000;
      count_q  <= 32'h0000_0000;
      squash_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      req_q    <= req_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      ipc_q    <= ipc_d;
      count_q  <= count_d;
      squash_q <= squash_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    addr_d   = addr_q;
    req_d    = req_q;
    valid_d  = valid_q;
    instr_d  = instr_q;
    ipc_d    = ipc_q;
    count_d  = count_q;
    squash_d = squash_q;
    case (state_q)
      ST_START: begin
        state_d = ST_REQ;
        req_d   = 1'b1;
        if (flush) begin
          pc_d   = flush_pc;
          addr_d = align_word(flush_pc);
        end else begin
          pc_d   = pc_q;
        end
      end
      ST_REQ: begin
        if (flush) begin
          pc_d = flush_pc;
          // Without an ack the old request must stay live; its response is dropped later.
          if (imem_ack) begin
            addr_d   = align_word(flush_pc);
            squash_d = 1'b0;
          end else begin
            squash_d = 1'b1;
          end
        end else if (imem_ack) begin
          if (squash_q) begin
            squash_d = 1'b0;
            addr_d   = align_word(pc_q);
          end else begin
            instr_d = imem_rdata;
            ipc_d   = pc_q;
            valid_d = 1'b1;
            req_d   = 1'b0;
            state_d = ST_HOLD;
          end
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_HOLD: begin
        if (flush || if_ready) begin
          pc_d    = flush ? flush_pc : next_pc;
          addr_d  = align_word(flush ? flush_pc : next_pc);
          count_d = if_ready ? (count_q + 32'd1) : count_q;
          valid_d = 1'b0;
          req_d   = 1'b1;
          state_d = ST_REQ;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_START;
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  assign pc          = pc_q;
  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign if_valid    = valid_q;
  assign if_instr    = instr_q;
  assign if_pc       = ipc_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized
// run checked against a transaction-level model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] next_pc = 32'h0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = 32'h0;
  logic [31:0] pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready = 1'b0;
  logic [31:0] fetch_count;

  int n_cmp = 0;
  int n_err = 0;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .next_pc(next_pc), .flush(flush), .flush_pc(flush_pc),
    .pc(pc), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_ready(if_ready), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({imem_req, if_valid, pc, imem_addr, if_instr, if_pc, fetch_count} !== {2'b00, 160'h0}) begin
      n_err++; $display("FAIL reset_values: req=%b valid=%b pc=%h addr=%h instr=%h ipc=%h cnt=%h, need all zero",
                        imem_req, if_valid, pc, imem_addr, if_instr, if_pc, fetch_count);
    end
    rst_n = 1'b1;
    tick(); tick();
    n_cmp++;
    if (imem_req !== 1'b1) begin n_err++; $display("FAIL reset_req_live: got %b need 1", imem_req); end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({imem_req, imem_addr} !== {1'b0, 32'h0}) begin
      n_err++; $display("FAIL reset_async: req=%b addr=%h need 0/0", imem_req, imem_addr);
    end
    tick(); tick(); tick();
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
      n_err++; $display("FAIL reset_release: req=%b addr=%h need 1/00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_zero_wait();
    if_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      imem_ack   = imem_req;
      imem_rdata = imem_addr ^ 32'hA5A5_0000;
      next_pc    = pc + 32'd4;
      tick();
      n_cmp++;
      if (k % 2 == 1) begin
        if ({if_valid, if_pc, if_instr} !== {1'b1, 32'((k / 2) * 4), 32'((k / 2) * 4) ^ 32'hA5A5_0000}) begin
          n_err++; $display("FAIL zero_wait_fetch%0d: valid=%b ipc=%h instr=%h need 1/%h/%h", k, if_valid, if_pc,
                            if_instr, 32'((k / 2) * 4), 32'((k / 2) * 4) ^ 32'hA5A5_0000);
        end
      end else begin
        if ({if_valid, imem_req, fetch_count} !== {2'b01, 32'(k / 2)}) begin
          n_err++; $display("FAIL zero_wait_handoff%0d: valid=%b req=%b cnt=%0d need 0/1/%0d", k, if_valid,
                            imem_req, fetch_count, k / 2);
        end
      end
    end
    imem_ack = 1'b0;
    if_ready = 1'b0;
  endtask

  task automatic test_stall();
    imem_ack = 1'b1; imem_rdata = 32'hCAFE_0010;
    tick();
    imem_ack = 1'b0; next_pc = 32'h40;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if ({if_valid, imem_req, if_pc, if_instr, pc} !== {2'b10, 32'h10, 32'hCAFE_0010, 32'h10}) begin
        n_err++; $display("FAIL stall_hold%0d: valid=%b req=%b ipc=%h instr=%h pc=%h need 1/0/10/cafe0010/10",
                          i, if_valid, imem_req, if_pc, if_instr, pc);
      end
    end
    if_ready = 1'b1;
    tick();
    if_ready = 1'b0;
    n_cmp++;
    if ({pc, imem_addr, imem_req, if_valid, fetch_count} !== {32'h40, 32'h40, 2'b10, 32'd5}) begin
      n_err++; $display("FAIL stall_release: pc=%h addr=%h req=%b valid=%b cnt=%0d need 40/40/1/0/5",
                        pc, imem_addr, imem_req, if_valid, fetch_count);
    end
  endtask

  task automatic test_flush_wait();
    imem_ack = 1'b1; imem_rdata = 32'h1111_1111;
    tick();
    imem_ack = 1'b0; if_ready = 1'b1; next_pc = 32'h8;
    tick();
    if_ready = 1'b0;
    flush = 1'b1; flush_pc = 32'h100;
    tick();
    flush = 1'b0;
    n_cmp++;
    if ({imem_addr, imem_req, pc} !== {32'h8, 1'b1, 32'h100}) begin
      n_err++; $display("FAIL flush_wait_hold: addr=%h req=%b pc=%h need 8/1/100", imem_addr, imem_req, pc);
    end
    tick();
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    n_cmp++;
    if ({if_valid, imem_req, imem_addr} !== {2'b01, 32'h100}) begin
      n_err++; $display("FAIL flush_wait_drop: valid=%b req=%b addr=%h need 0/1/100", if_valid, imem_req, imem_addr);
    end
    tick();
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    tick();
    imem_ack = 1'b0;
    n_cmp++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h100, 32'h1234_5678}) begin
      n_err++; $display("FAIL flush_wait_refetch: valid=%b ipc=%h instr=%h need 1/100/12345678",
                        if_valid, if_pc, if_instr);
    end
  endtask

  task automatic test_flush_handoff();
    if_ready = 1'b1; next_pc = 32'h20; flush = 1'b1; flush_pc = 32'h300;
    tick();
    if_ready = 1'b0; flush = 1'b0;
    n_cmp++;
    if ({fetch_count, pc, imem_addr, imem_req, if_valid} !== {32'd7, 32'h300, 32'h300, 2'b10}) begin
      n_err++; $display("FAIL flush_handoff: cnt=%0d pc=%h addr=%h req=%b valid=%b need 7/300/300/1/0",
                        fetch_count, pc, imem_addr, imem_req, if_valid);
    end
  endtask

  task automatic test_unaligned();
    imem_ack = 1'b1; imem_rdata = 32'h0000_0300;
    tick();
    imem_ack = 1'b0; if_ready = 1'b1; next_pc = 32'h13;
    tick();
    if_ready = 1'b0;
    n_cmp++;
    if ({pc, imem_addr, fetch_count} !== {32'h13, 32'h10, 32'd8}) begin
      n_err++; $display("FAIL unaligned: pc=%h addr=%h cnt=%0d need 13/10/8", pc, imem_addr, fetch_count);
    end
    imem_ack = 1'b1; imem_rdata = 32'h0000_0013;
    tick();
    imem_ack = 1'b0;
    n_cmp++;
    if ({if_valid, if_pc} !== {1'b1, 32'h13}) begin
      n_err++; $display("FAIL unaligned_ipc: valid=%b ipc=%h need 1/13", if_valid, if_pc);
    end
  endtask

  // Transaction-level reference: phase is implied by "request open" / "instruction held".
  logic [31:0] m_pc, m_addr, m_instr, m_ipc, m_cnt;
  logic        m_req, m_valid, m_drop;

  task automatic model_step(input logic fl, input logic [31:0] fpc, input logic ack,
                            input logic [31:0] rd, input logic rdy, input logic [31:0] npc);
    if (!m_req && !m_valid) begin
      m_req = 1'b1;
      if (fl) begin m_pc = fpc; m_addr = fpc & 32'hFFFF_FFFC; end
    end else if (m_req) begin
      if (fl) begin
        m_pc = fpc;
        if (ack) begin m_addr = fpc & 32'hFFFF_FFFC; m_drop = 1'b0; end
        else m_drop = 1'b1;
      end else if (ack) begin
        if (m_drop) begin m_drop = 1'b0; m_addr = m_pc & 32'hFFFF_FFFC; end
        else begin m_instr = rd; m_ipc = m_pc; m_valid = 1'b1; m_req = 1'b0; end
      end
    end else if (fl || rdy) begin
      if (rdy) m_cnt = m_cnt + 32'd1;
      m_pc    = fl ? fpc : npc;
      m_addr  = m_pc & 32'hFFFF_FFFC;
      m_valid = 1'b0;
      m_req   = 1'b1;
    end
  endtask

  task automatic test_random();
    rst_n = 1'b0; flush = 1'b0; imem_ack = 1'b0; if_ready = 1'b0;
    tick();
    m_pc = 32'h0; m_addr = 32'h0; m_instr = 32'h0; m_ipc = 32'h0; m_cnt = 32'h0;
    m_req = 1'b0; m_valid = 1'b0; m_drop = 1'b0;
    rst_n = 1'b1;
    for (int c = 0; c < 400; c++) begin
      flush      = ($urandom_range(0, 9) == 0);
      flush_pc   = $urandom;
      imem_ack   = m_req && ($urandom_range(0, 1) == 1);
      imem_rdata = $urandom;
      if_ready   = ($urandom_range(0, 4) < 3);
      next_pc    = ($urandom_range(0, 3) == 0) ? 32'($urandom) : (m_pc + 32'd4);
      model_step(flush, flush_pc, imem_ack, imem_rdata, if_ready, next_pc);
      tick();
      n_cmp++;
      if ({pc, imem_addr, imem_req, if_valid, if_instr, if_pc, fetch_count} !==
          {m_pc, m_addr, m_req, m_valid, m_instr, m_ipc, m_cnt}) begin
        n_err++; $display("FAIL random_c%0d: dut pc=%h addr=%h req=%b v=%b instr=%h ipc=%h cnt=%h model %h %h %b %b %h %h %h",
                          c, pc, imem_addr, imem_req, if_valid, if_instr, if_pc, fetch_count,
                          m_pc, m_addr, m_req, m_valid, m_instr, m_ipc, m_cnt);
      end
    end
    flush = 1'b0; imem_ack = 1'b0; if_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_stall();
    test_flush_wait();
    test_flush_handoff();
    test_unaligned();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
